// File: rtl/serial_adder_pkg.sv
// Shared state encoding for the bit-serial adder.
package serial_adder_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = S_IDLE,
        RUN  = S_RUN,
        DONE = S_DONE
    } state_t;

endpackage

// File: rtl/fa_using_hs.sv
// Single-bit full adder built from two half-adder stages.
module fa_using_hs (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    logic w_s1;
    logic w_c1;

    assign w_s1  = a ^ b;
    assign w_c1  = a & b;
    assign sum   = w_s1 ^ c;
    assign carry = w_c1 | (w_s1 & c);

endmodule

// File: rtl/serial_adder_slice.sv
// Per-bit combinational datapath of the serial adder: one full-adder cell.
module serial_adder_slice (
    input  logic i_a,
    input  logic i_b,
    input  logic i_carry,
    output logic o_sum,
    output logic o_carry
);

    fa_using_hs u_fa (
        .a     (i_a),
        .b     (i_b),
        .c     (i_carry),
        .sum   (o_sum),
        .carry (o_carry)
    );

endmodule

// File: rtl/serial_adder.sv
// Bit-serial W-bit adder: LSB-first through one full-adder cell, carry held in a flop.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    state_t          r_state;
    state_t          w_next_state;
    logic [W-1:0]    r_a_sh;
    logic [W-1:0]    r_b_sh;
    logic [W-1:0]    r_res_sh;
    logic [W-1:0]    w_res_next;
    logic            r_carry;
    logic [CW-1:0]   r_cnt;
    logic [W-1:0]    r_sum;
    logic            r_cout;
    logic            w_s;
    logic            w_c;
    logic            w_accept;
    logic            w_last;

    serial_adder_slice u_slice (
        .i_a     (r_a_sh[0]),
        .i_b     (r_b_sh[0]),
        .i_carry (r_carry),
        .o_sum   (w_s),
        .o_carry (w_c)
    );

    // W=1 has no upper result bits to shift down.
    generate
        if (W == 1) begin : g_res_w1
            assign w_res_next = w_s;
        end else begin : g_res_wn
            assign w_res_next = {w_s, r_res_sh[W-1:1]};
        end
    endgenerate

    assign w_accept = start && (r_state != RUN);
    assign w_last   = (r_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start) w_next_state = RUN;
            RUN:     if (w_last) w_next_state = DONE;
            DONE:    w_next_state = start ? RUN : IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_res_sh <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
        end else if (w_accept) begin
            r_a_sh  <= op_a;
            r_b_sh  <= op_b;
            r_carry <= cin;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_res_sh <= w_res_next;
            r_a_sh   <= r_a_sh >> 1;
            r_b_sh   <= r_b_sh >> 1;
            r_carry  <= w_c;
            if (w_last) begin
                r_sum  <= w_res_next;
                r_cout <= w_c;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder at W=8.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int checks;
    int failures;

    serial_adder #(.W(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op_a  (op_a),
        .op_b  (op_b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive a request at the current negedge; return one negedge later (first RUN cycle).
    task automatic kick(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        cin   = ci;
        @(negedge clk);
        start = 1'b0;
        op_a  = 8'hA5;
        op_b  = 8'h5A;
        cin   = 1'b1;
        check("kick_busy", 32'(busy), 32'd1);
        check("kick_done", 32'(done), 32'd0);
    endtask

    // Waits for done; inject>0 pulses start with 0x10+0x10 at that RUN cycle.
    task automatic wait_done(input logic [W-1:0] exp_sum, input logic exp_cout,
                             input logic [W-1:0] prev_sum, input int inject);
        int n;
        bit seen;
        n = 1;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (n == inject) begin
                start = 1'b1;
                op_a  = 8'h10;
                op_b  = 8'h10;
                cin   = 1'b0;
            end
            @(negedge clk);
            start = 1'b0;
            n++;
            if (done) begin
                seen = 1'b1;
                break;
            end
            check("run_busy", 32'(busy), 32'd1);
            check("run_sum_hold", 32'(sum), 32'(prev_sum));
        end
        check("done_seen", 32'(seen), 32'd1);
        check("latency", 32'(n), 32'(W + 1));
        check("sum", 32'(sum), 32'(exp_sum));
        check("cout", 32'(cout), 32'(exp_cout));
        check("done_busy", 32'(busy), 32'd0);
    endtask

    task automatic idle_watch(input int cycles, input logic [W-1:0] exp_sum, input logic exp_cout);
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            check("idle_done", 32'(done), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_sum", 32'(sum), 32'(exp_sum));
            check("idle_cout", 32'(cout), 32'(exp_cout));
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst   = 1'b1;
        start = 1'b1;
        op_a  = 8'hFF;
        op_b  = 8'hFF;
        cin   = 1'b1;

        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_done", 32'(done), 32'd0);
            check("rst_sum", 32'(sum), 32'd0);
            check("rst_cout", 32'(cout), 32'd0);
        end
        rst   = 1'b0;
        start = 1'b0;
        idle_watch(2, 8'h00, 1'b0);

        kick(8'h5A, 8'h3C, 1'b0);
        wait_done(8'h96, 1'b0, 8'h00, -1);
        idle_watch(2, 8'h96, 1'b0);

        kick(8'hFF, 8'h01, 1'b0);
        wait_done(8'h00, 1'b1, 8'h96, -1);
        idle_watch(1, 8'h00, 1'b1);

        kick(8'hFF, 8'hFF, 1'b1);
        wait_done(8'hFF, 1'b1, 8'h00, -1);
        idle_watch(1, 8'hFF, 1'b1);

        // Request on RUN cycle 3 must be dropped.
        kick(8'h01, 8'h01, 1'b0);
        wait_done(8'h02, 1'b0, 8'hFF, 3);
        idle_watch(12, 8'h02, 1'b0);

        // Back-to-back: accept during the DONE cycle.
        kick(8'h01, 8'h01, 1'b0);
        wait_done(8'h02, 1'b0, 8'h02, -1);
        kick(8'h80, 8'h80, 1'b0);
        wait_done(8'h00, 1'b1, 8'h02, -1);
        idle_watch(1, 8'h00, 1'b1);

        // Mid-run reset on RUN cycle 4.
        kick(8'h11, 8'h22, 1'b0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        idle_watch(12, 8'h00, 1'b0);

        kick(8'h03, 8'h04, 1'b0);
        wait_done(8'h07, 1'b0, 8'h00, -1);
        idle_watch(2, 8'h07, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial W-bit adder. It is the sequential stage that drives the team's single-bit full-adder cell and consumes its sum/carry.
- Each run accepts two W-bit operands plus carry-in, feeds one bit pair per clock (LSB first) through the full-adder cell, and recirculates the carry through a flip-flop.
- Presents a registered W-bit sum and carry-out with a one-cycle done pulse.
- Used where area matters more than latency, e.g. accumulate paths and checksum units.

Parameters:
- W, 8, operand/result width in bits; legal range 1..32.

Ports:
- clk    in   1  rising-edge clock
- rst    in   1  synchronous, active-high reset
- start  in   1  request a new addition; sampled only when not busy
- op_a   in   W  operand A, captured on the accepting edge
- op_b   in   W  operand B, captured on the accepting edge
- cin    in   1  carry-in, captured on the accepting edge
- busy   out  1  high while bits are being processed (RUN state)
- done   out  1  one-cycle pulse; result valid and stable
- sum    out  W  registered result; holds until the next completion
- cout   out  1  registered carry-out; holds until the next completion

Behaviour:
- Reset: rst high at a rising edge forces state=IDLE, busy=0, done=0, sum=0, cout=0, and clears the internal shift registers, carry flop and bit counter. This applies in any state, including mid-RUN. An aborted run produces no done pulse and leaves sum=0.
- States: IDLE, RUN, DONE. Encoding is 2-bit binary. busy=(state==RUN); done=(state==DONE). Both are decoded from registered state, so they are glitch-free.
- IDLE: start=1 at an edge loads a_sh<=op_a, b_sh<=op_b, carry<=cin, cnt<=0, then state<=RUN. With start=0 the block stays in IDLE.
- RUN, per edge:
  - fa_cell computes s=a_sh[0]^b_sh[0]^carry and c=majority(a_sh[0],b_sh[0],carry).
  - res_sh<={s,res_sh[W-1:1]}; a_sh and b_sh shift right by 1 (zero fill); carry<=c.
  - If cnt==W-1: sum<={s,res_sh[W-1:1]}, cout<=c, state<=DONE. Otherwise cnt<=cnt+1.
- RUN ignores start: no capture and no queuing. Operand inputs may change freely during RUN.
- DONE lasts exactly one cycle, then state<=IDLE. If start=1 at that edge, the block behaves as in IDLE: it loads and goes straight to RUN. Back-to-back runs therefore incur one dead cycle.
- Latency: done is high in the cycle that begins exactly W+1 rising edges after the accepting edge (accept edge, W RUN edges, then DONE). Throughput is one result per W+1 cycles.
- sum/cout update only on the RUN-to-DONE edge. They stay stable through the following IDLE cycles and the whole next RUN.
- Arithmetic: {cout,sum} = op_a + op_b + cin, modulo 2^(W+1). Unsigned; no overflow flag.
- cnt width: max(1,$clog2(W)). For W=1, RUN lasts one edge (cnt==0 terminates immediately).
- rst and start both high: rst wins.

Decomposition:
- Shared package/include serial_adder_pkg: state localparams S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2.
- One natural sub-module: the bit slice instantiates the team's existing full-adder cell fa_using_hs (ports a, b, c, sum, carry) as the per-bit combinational datapath.
- Control FSM, counter and shift registers live in serial_adder.

Test Plan:
- Reset: hold rst=1 for 3 clocks with start=1 -> busy=0, done=0, sum=0x00, cout=0 throughout.
- W=8, op_a=0x5A, op_b=0x3C, cin=0 -> busy high for 8 cycles, done pulses once 9 edges after accept, sum=0x96, cout=0.
- W=8, 0xFF+0x01, cin=0 -> sum=0x00, cout=1. Then 0xFF+0xFF with cin=1 -> sum=0xFF, cout=1.
- Start while busy: accept 0x01+0x01, assert start with op_a=0x10, op_b=0x10 on RUN cycle 3 -> exactly one done, sum=0x02; second request is dropped.
- Back-to-back: hold start=1 with a new operand pair (0x80+0x80, cin=0) during the DONE cycle -> accepted, busy rises next cycle, sum=0x00, cout=1 nine edges later. The previous sum holds until then.
- Mid-run reset: rst=1 on RUN cycle 4 -> next cycle state IDLE, busy=0, sum=0, no done. A fresh 0x03+0x04 run afterwards gives sum=0x07.
